// File: rtl/main_mem_responder.sv
// Line-granular backing memory for the cache fill/write-back port.
// One request in flight; fixed read/write latency with a completion pulse.
module main_mem_responder #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int CACHE_WORD_WIDTH = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int RD_LATENCY       = 3,
  parameter int WR_LATENCY       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       addr_main,
  input  logic                        addr_main_en,
  input  logic                        data_main_vld,
  input  logic [CACHE_WORD_WIDTH-1:0] data_main_wr,
  output logic [CACHE_WORD_WIDTH-1:0] data_main_rd,
  output logic                        data_main_rd_vld,
  output logic                        wr_done,
  output logic                        mem_busy,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count
);

  localparam int OFFSET_WIDTH =
    $clog2(CACHE_WORD_WIDTH) - $clog2(DATA_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE, RD_WAIT, WR_WAIT, DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic [CACHE_WORD_WIDTH-1:0] wdata_q;
  logic [CACHE_WORD_WIDTH-1:0] mem [MEM_DEPTH];

  logic accept;
  logic fire_rd;
  logic fire_wr;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fire_idx;
  logic [CACHE_WORD_WIDTH-1:0] fire_data;
  logic unused_addr;

  assign req_idx     = addr_main[OFFSET_WIDTH +: IDX_W];
  assign unused_addr = ^addr_main;
  assign mem_busy    = (state_q != IDLE);

  // A latency of 1 completes on the accept edge itself.
  assign fire_idx  = accept ? req_idx : idx_q;
  assign fire_data = accept ? data_main_wr : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire_rd = 1'b0;
    fire_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (addr_main_en) begin
          accept = 1'b1;
          if (data_main_vld) begin
            if (WR_LATENCY == 1) begin
              fire_wr = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = 4'(WR_LATENCY - 1);
              state_d = WR_WAIT;
            end
          end else begin
            if (RD_LATENCY == 1) begin
              fire_rd = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = 4'(RD_LATENCY - 1);
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd1) begin
          fire_rd = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd1) begin
          fire_wr = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      data_main_rd     <= '0;
      data_main_rd_vld <= 1'b0;
      wr_done          <= 1'b0;
      rd_count         <= '0;
      wr_count         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      data_main_rd_vld <= fire_rd;
      wr_done          <= fire_wr;
      if (fire_rd) begin
        data_main_rd <= mem[fire_idx];
      end
      if (fire_rd && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (fire_wr && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      wdata_q <= data_main_wr;
    end
  end

  // Reset wins over a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && fire_wr) begin
      mem[fire_idx] <= fire_data;
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: timing model plus directed scenarios.
// Outputs are compared every cycle on the falling edge.
module tb_main_mem_responder;

  localparam int RDL = 3;
  localparam int WRL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        en;
  logic        vld;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvld;
  logic        wdone;
  logic        busy;
  logic [15:0] rc;
  logic [15:0] wc;

  main_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .addr_main       (addr),
    .addr_main_en    (en),
    .data_main_vld   (vld),
    .data_main_wr    (wdata),
    .data_main_rd    (rdata),
    .data_main_rd_vld(rvld),
    .wr_done         (wdone),
    .mem_busy        (busy),
    .rd_count        (rc),
    .wr_count        (wc)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted request completes LAT cycles later.
  logic [31:0] mem_m [256];
  bit          m_act = 1'b0;
  bit          m_wr;
  int          m_pulse;
  int          m_idx;
  logic [31:0] m_data;
  logic        e_busy, e_rvld, e_wdone;
  logic [31:0] e_rd;
  logic [15:0] e_rc, e_wc;

  always @(posedge clk) begin
    bit was;
    if (rst) begin
      m_act   = 1'b0;
      e_busy  = 1'b0;
      e_rvld  = 1'b0;
      e_wdone = 1'b0;
      e_rd    = '0;
      e_rc    = '0;
      e_wc    = '0;
    end else begin
      was     = m_act;
      e_rvld  = 1'b0;
      e_wdone = 1'b0;
      if (m_act && cyc == m_pulse) m_act = 1'b0;
      if (!was && en) begin
        m_act   = 1'b1;
        m_wr    = vld;
        m_idx   = (int'(addr) / 4) % 256;
        m_data  = wdata;
        m_pulse = cyc + (vld ? WRL : RDL);
      end
      if (m_act && cyc + 1 == m_pulse) begin
        if (m_wr) begin
          mem_m[m_idx] = m_data;
          e_wdone = 1'b1;
          if (e_wc != 16'hFFFF) e_wc = e_wc + 16'd1;
        end else begin
          e_rd   = mem_m[m_idx];
          e_rvld = 1'b1;
          if (e_rc != 16'hFFFF) e_rc = e_rc + 16'd1;
        end
      end
      e_busy = m_act;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("rd_vld", {31'd0, rvld}, {31'd0, e_rvld});
      check("wr_done", {31'd0, wdone}, {31'd0, e_wdone});
      check("rd_data", rdata, e_rd);
      check("rd_count", {16'd0, rc}, {16'd0, e_rc});
      check("wr_count", {16'd0, wc}, {16'd0, e_wc});
      check("excl", {31'd0, rvld & wdone}, 32'd0);
    end
  end

  task automatic issue(input logic [15:0] a, input bit w,
                       input logic [31:0] d, output int acc);
    addr  = a;
    vld   = w;
    wdata = d;
    en    = 1'b1;
    acc   = cyc;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    int t;
    wait_idle();
    issue(a, 1'b1, d, t);
    goto(t + WRL);
    check("wr_pulse", {31'd0, wdone}, 32'd1);
  endtask

  task automatic do_read(input string nm, input logic [15:0] a,
                         input logic [31:0] exp);
    int t;
    wait_idle();
    issue(a, 1'b0, 32'd0, t);
    goto(t + RDL);
    check({nm, "_vld"}, {31'd0, rvld}, 32'd1);
    check(nm, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r, t, s, nw, nr;
    rst = 1'b1; en = 1'b0; vld = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rc", {16'd0, rc}, 32'd0);
    check("rst_wc", {16'd0, wc}, 32'd0);
    check("rst_rd", rdata, 32'd0);

    // Write-then-read with exact pulse timing
    issue(16'h0104, 1'b1, 32'hDEADBEEF, a);
    goto(a + 1);
    check("t1_wr_early", {31'd0, wdone}, 32'd0);
    goto(a + 2);
    check("t1_wr_done", {31'd0, wdone}, 32'd1);
    check("t1_wc", {16'd0, wc}, 32'd1);
    goto(a + 3);
    issue(16'h0104, 1'b0, 32'd0, r);
    goto(r + 2);
    check("t1_rd_early", {31'd0, rvld}, 32'd0);
    goto(r + 3);
    check("t1_rd_vld", {31'd0, rvld}, 32'd1);
    check("t1_rd", rdata, 32'hDEADBEEF);
    check("t1_rc", {16'd0, rc}, 32'd1);

    // Offset bits ignored, upper bits alias
    do_write(16'h0010, 32'h11223344);
    do_write(16'h0014, 32'h55667788);
    do_read("t2_off", 16'h0013, 32'h11223344);
    do_read("t2_alias", 16'h0410, 32'h11223344);
    do_read("t2_next", 16'h0014, 32'h55667788);

    // Request during busy is dropped
    do_write(16'h0020, 32'hA5A5A5A5);
    wait_idle();
    issue(16'h0020, 1'b0, 32'd0, t);
    addr = 16'h0020; vld = 1'b1; wdata = 32'h0BADF00D; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    nw = 0; nr = 0;
    while (cyc <= t + 8) begin
      nw += int'(wdone);
      nr += int'(rvld);
      if (cyc == t + 3) check("t3_rd", rdata, 32'hA5A5A5A5);
      @(negedge clk);
    end
    check("t3_no_wr", nw, 32'd0);
    check("t3_one_rd", nr, 32'd1);
    do_read("t3_line", 16'h0020, 32'hA5A5A5A5);

    // Reset aborts an uncommitted write
    do_write(16'h0030, 32'h00000000);
    wait_idle();
    issue(16'h0030, 1'b1, 32'hCAFEF00D, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_wc", {16'd0, wc}, 32'd0);
    goto(t + 5);
    do_read("t4_old", 16'h0030, 32'h00000000);
    check("t4_rc", {16'd0, rc}, 32'd1);

    // Back-to-back reads with the strobe held high
    wait_idle();
    s = cyc;
    addr = 16'h0104; vld = 1'b0; en = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      if (i == 13) en = 1'b0;
      check("t5_vld", {31'd0, rvld}, {31'd0, (i % 4 == 3) && i < 16});
      if (i == 15) check("t5_rd", rdata, 32'hDEADBEEF);
      @(negedge clk);
    end

    // Write counter saturation with a preloaded value
    wait_idle();
    #2;
    dut.wr_count = 16'hFFFE;
    e_wc = 16'hFFFE;
    @(negedge clk);
    do_write(16'h0040, 32'h00000001);
    check("t6_sat1", {16'd0, wc}, 32'h0000FFFF);
    do_write(16'h0044, 32'h00000002);
    check("t6_sat2", {16'd0, wc}, 32'h0000FFFF);
    wait_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst", {16'd0, wc}, 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
